fp_divsqrt_arbiter: RTL and testbench

//  Shares one iterative FP32 div/sqrt core among NUM_LANES FP issue lanes via the

---
 rtl/fp_divsqrt_arbiter.sv | 168 ++++++++++++++++
 tb/tb_fp_divsqrt_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_divsqrt_arbiter.sv
// Round-robin arbiter sharing one iterative FP32 div/sqrt core among NUM_LANES lanes.
// Optional RESERVED-state watchdog enabled by defining FP_DIVSQRT_ARB_TIMEOUT_EN.
module fp_divsqrt_arbiter #(
  parameter int NUM_LANES      = 2,
  parameter int LANE_W         = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_LANES-1:0]   reserveReq,
  input  logic [NUM_LANES-1:0]   req,
  input  logic [NUM_LANES-1:0]   isDivide,
  input  logic [NUM_LANES*32-1:0] dataInA,
  input  logic [NUM_LANES*32-1:0] dataInB,
  input  logic [NUM_LANES*3-1:0] rm,
  input  logic [NUM_LANES-1:0]   flush,
  input  logic [NUM_LANES-1:0]   releaseReq,
  output logic [NUM_LANES-1:0]   reserved,
  output logic [NUM_LANES-1:0]   finished,
  output logic [31:0]            dataOut,
  output logic [4:0]             fflagsOut,
  output logic                   coreStart,
  output logic                   coreIsDivide,
  output logic [31:0]            coreA,
  output logic [31:0]            coreB,
  output logic [2:0]             coreRm,
  output logic                   coreAbort,
  input  logic                   coreDone,
  input  logic [31:0]            coreResult,
  input  logic [4:0]             coreFFlags,
  output logic                   timeoutPulse
);

  typedef enum logic [1:0] {FREE, RESERVED, BUSY, FINISHED} state_t;

  state_t            state, nextState;
  logic [LANE_W-1:0] owner, nextOwner, rrPtr, nextRrPtr, grantIdx, cand;
  logic              grantValid, timeoutHit;
  logic [NUM_LANES-1:0] reservedNxt, finishedNxt;
  logic              startNxt, abortNxt, captureNxt;

  if (NUM_LANES < 1 || TIMEOUT_CYCLES < 1) begin : g_badParam
    $error("fp_divsqrt_arbiter: NUM_LANES and TIMEOUT_CYCLES must be >= 1");
  end

  // First requesting lane at or after rrPtr, wrapping around.
  always_comb begin
    grantValid = 1'b0;
    grantIdx   = '0;
    cand       = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      cand = LANE_W'((int'(rrPtr) + i) % NUM_LANES);
      if (!grantValid && reserveReq[cand]) begin
        grantValid = 1'b1;
        grantIdx   = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FREE;
      owner <= '0;
      rrPtr <= '0;
    end else begin
      state <= nextState;
      owner <= nextOwner;
      rrPtr <= nextRrPtr;
    end
  end

  always_comb begin
    nextState = state;
    nextOwner = owner;
    nextRrPtr = rrPtr;
    case (state)
      FREE: begin
        if (grantValid) begin
          nextState = RESERVED;
          nextOwner = grantIdx;
          nextRrPtr = LANE_W'((int'(grantIdx) + 1) % NUM_LANES);
        end
      end
      RESERVED: begin
        if (flush[owner] || timeoutHit) nextState = FREE;
        else if (req[owner])            nextState = BUSY;
      end
      BUSY: begin
        if (flush[owner])  nextState = FREE;
        else if (coreDone) nextState = FINISHED;
      end
      FINISHED: begin
        if (releaseReq[owner] || flush[owner]) nextState = FREE;
      end
      default: nextState = FREE;
    endcase
  end

  // Outputs are derived from the upcoming state so they register in step with it.
  always_comb begin
    reservedNxt = '0;
    finishedNxt = '0;
    if (nextState != FREE)     reservedNxt[nextOwner] = 1'b1;
    if (nextState == FINISHED) finishedNxt[nextOwner] = 1'b1;
    startNxt   = (state == RESERVED) && (nextState == BUSY);
    abortNxt   = (state == BUSY) && flush[owner] && !coreDone;
    captureNxt = (state == BUSY) && (nextState == FINISHED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reserved     <= '0;
      finished     <= '0;
      coreStart    <= 1'b0;
      coreAbort    <= 1'b0;
      coreIsDivide <= 1'b0;
      coreA        <= '0;
      coreB        <= '0;
      coreRm       <= '0;
      dataOut      <= '0;
      fflagsOut    <= '0;
    end else begin
      reserved  <= reservedNxt;
      finished  <= finishedNxt;
      coreStart <= startNxt;
      coreAbort <= abortNxt;
      if (startNxt) begin
        coreIsDivide <= isDivide[owner];
        coreA        <= dataInA[owner*32 +: 32];
        coreB        <= dataInB[owner*32 +: 32];
        coreRm       <= rm[owner*3 +: 3];
      end
      if (captureNxt) begin
        dataOut   <= coreResult;
        fflagsOut <= coreFFlags;
      end
    end
  end

`ifdef FP_DIVSQRT_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] waitCnt, waitCntNxt;
  logic             pulseNxt;

  // The pulse marks the final allowed RESERVED cycle; the FSM leaves at its end.
  always_comb begin
    waitCntNxt = (state == RESERVED) ? waitCnt + 1'b1 : '0;
    pulseNxt   = (nextState == RESERVED) && (waitCntNxt == CNT_W'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waitCnt      <= '0;
      timeoutPulse <= 1'b0;
    end else begin
      waitCnt      <= waitCntNxt;
      timeoutPulse <= pulseNxt;
    end
  end

  assign timeoutHit = timeoutPulse;
`else
  assign timeoutHit   = 1'b0;
  assign timeoutPulse = 1'b0;
`endif

endmodule

// File: tb/tb_fp_divsqrt_arbiter.sv
// Self-checking bench for fp_divsqrt_arbiter: directed scenarios plus a randomized
// run compared against a lane-ownership reference model.
module tb_fp_divsqrt_arbiter;

  localparam int N  = 2;
  localparam int TO = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    reserveReq, req, isDivide, flush, releaseReq;
  logic [N*32-1:0] dataInA, dataInB;
  logic [N*3-1:0]  rm;
  logic [N-1:0]    reserved, finished;
  logic [31:0]     dataOut, coreA, coreB, coreResult;
  logic [4:0]      fflagsOut, coreFFlags;
  logic            coreStart, coreIsDivide, coreAbort, coreDone, timeoutPulse;
  logic [2:0]      coreRm;

  int testsRun    = 0;
  int testsFailed = 0;

  fp_divsqrt_arbiter #(.NUM_LANES(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .reserveReq(reserveReq), .req(req), .isDivide(isDivide),
    .dataInA(dataInA), .dataInB(dataInB), .rm(rm), .flush(flush), .releaseReq(releaseReq),
    .reserved(reserved), .finished(finished), .dataOut(dataOut), .fflagsOut(fflagsOut),
    .coreStart(coreStart), .coreIsDivide(coreIsDivide), .coreA(coreA), .coreB(coreB),
    .coreRm(coreRm), .coreAbort(coreAbort), .coreDone(coreDone), .coreResult(coreResult),
    .coreFFlags(coreFFlags), .timeoutPulse(timeoutPulse)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [N-1:0] rr, input logic [N-1:0] rq,
                               input logic [N-1:0] rl, input logic [N-1:0] fl);
    reserveReq = rr;
    req        = rq;
    releaseReq = rl;
    flush      = fl;
  endtask

  task automatic doReset;
    applyStimulus('0, '0, '0, '0);
    coreDone = 1'b0;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    doReset;
    testsRun++;
    if ({reserved, finished, coreStart, coreAbort, dataOut, fflagsOut} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_state: got res=%b fin=%b data=%h expected all zero", reserved, finished, dataOut);
    end
    applyStimulus(2'b01, '0, '0, '0); tick;
    applyStimulus('0, 2'b01, '0, '0); tick;
    applyStimulus('0, '0, '0, '0);    tick;
    rst = 1'b1;
    #2;
    testsRun++;
    if ({reserved, finished, coreStart, coreA} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid_busy: got res=%b fin=%b start=%b coreA=%h expected zero", reserved, finished, coreStart, coreA);
    end
    tick;
    rst = 1'b0;
    tick;
    applyStimulus(2'b11, '0, '0, '0); tick;
    testsRun++;
    if (reserved !== 2'b01) begin
      testsFailed++;
      $display("[TB] FAIL reset_rrptr: got %b expected 01", reserved);
    end
    applyStimulus('0, '0, '0, 2'b01); tick;
    applyStimulus('0, '0, '0, '0);
  endtask

  task automatic test_round_robin;
    logic [N-1:0] expSeq [5] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
    logic [N-1:0] flushSeq [5] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
    doReset;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(2'b11, '0, '0, (i == 0) ? 2'b00 : flushSeq[i-1]);
      tick;
      testsRun++;
      if (reserved !== expSeq[i]) begin
        testsFailed++;
        $display("[TB] FAIL rr_step%0d: got %b expected %b", i, reserved, expSeq[i]);
      end
    end
    applyStimulus('0, '0, '0, 2'b01); tick;
    applyStimulus('0, '0, '0, '0);    tick;
  endtask

  task automatic test_divide;
    applyStimulus(2'b01, '0, '0, '0); tick;
    testsRun++;
    if (reserved !== 2'b01) begin
      testsFailed++;
      $display("[TB] FAIL div_grant: got %b expected 01", reserved);
    end
    applyStimulus('0, 2'b01, '0, '0); tick;
    testsRun++;
    if ({coreStart, coreIsDivide, coreA, coreB, coreRm} !== {2'b11, 32'h40400000, 32'h3F800000, 3'b001}) begin
      testsFailed++;
      $display("[TB] FAIL div_start: got start=%b div=%b A=%h B=%h rm=%b expected 1 1 40400000 3f800000 001",
               coreStart, coreIsDivide, coreA, coreB, coreRm);
    end
    applyStimulus('0, '0, '0, '0);
    for (int i = 0; i < 10; i++) begin
      tick;
      testsRun++;
      if ({coreStart, finished} !== 3'b000) begin
        testsFailed++;
        $display("[TB] FAIL div_wait%0d: got start=%b fin=%b expected 0 00", i, coreStart, finished);
      end
    end
    coreDone = 1'b1; coreResult = 32'h40400000; coreFFlags = 5'h01;
    tick;
    coreDone = 1'b0; coreResult = 32'hDEADBEEF; coreFFlags = 5'h1F;
    testsRun++;
    if ({finished, dataOut, fflagsOut} !== {2'b01, 32'h40400000, 5'h01}) begin
      testsFailed++;
      $display("[TB] FAIL div_result: got fin=%b data=%h flags=%h expected 01 40400000 01", finished, dataOut, fflagsOut);
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      testsRun++;
      if ({finished, dataOut} !== {2'b01, 32'h40400000}) begin
        testsFailed++;
        $display("[TB] FAIL div_hold%0d: got fin=%b data=%h expected 01 40400000", i, finished, dataOut);
      end
    end
    applyStimulus('0, '0, 2'b01, '0); tick;
    applyStimulus('0, '0, '0, '0);
    testsRun++;
    if ({reserved, finished, dataOut} !== {4'b0000, 32'h40400000}) begin
      testsFailed++;
      $display("[TB] FAIL div_release: got res=%b fin=%b data=%h expected 00 00 40400000", reserved, finished, dataOut);
    end
  endtask

  task automatic test_flush;
    applyStimulus(2'b10, '0, '0, '0); tick;
    applyStimulus('0, 2'b10, '0, '0); tick;
    testsRun++;
    if ({reserved, coreStart, coreA} !== {2'b10, 1'b1, 32'h41200000}) begin
      testsFailed++;
      $display("[TB] FAIL flush_start: got res=%b start=%b A=%h expected 10 1 41200000", reserved, coreStart, coreA);
    end
    applyStimulus('0, '0, '0, 2'b10); tick;
    testsRun++;
    if ({coreAbort, reserved} !== 3'b100) begin
      testsFailed++;
      $display("[TB] FAIL flush_abort: got abort=%b res=%b expected 1 00", coreAbort, reserved);
    end
    applyStimulus('0, '0, '0, '0); tick;
    testsRun++;
    if (coreAbort !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL flush_abort_len: got %b expected 0", coreAbort);
    end
    applyStimulus(2'b10, '0, '0, '0); tick;
    applyStimulus('0, 2'b10, '0, '0); tick;
    applyStimulus('0, '0, '0, 2'b10);
    coreDone = 1'b1; coreResult = 32'h12345678;
    tick;
    coreDone = 1'b0;
    applyStimulus('0, '0, '0, '0);
    testsRun++;
    if ({coreAbort, reserved, finished} !== 5'b00000) begin
      testsFailed++;
      $display("[TB] FAIL flush_done: got abort=%b res=%b fin=%b expected 0 00 00", coreAbort, reserved, finished);
    end
    tick;
    testsRun++;
    if ({finished, dataOut} !== {2'b00, 32'h40400000}) begin
      testsFailed++;
      $display("[TB] FAIL flush_discard: got fin=%b data=%h expected 00 40400000", finished, dataOut);
    end
  endtask

  task automatic test_non_owner;
    applyStimulus(2'b01, '0, '0, '0); tick;
    applyStimulus('0, 2'b01, '0, '0); tick;
    applyStimulus(2'b10, 2'b10, 2'b10, '0);
    for (int i = 0; i < 3; i++) begin
      tick;
      testsRun++;
      if ({reserved, finished, coreStart} !== 5'b01000) begin
        testsFailed++;
        $display("[TB] FAIL nonowner_busy%0d: got res=%b fin=%b start=%b expected 01 00 0", i, reserved, finished, coreStart);
      end
    end
    coreDone = 1'b1; coreResult = 32'h3F000000; coreFFlags = 5'h04;
    tick;
    coreDone = 1'b0;
    applyStimulus(2'b10, 2'b10, 2'b10, 2'b10);
    tick;
    testsRun++;
    if ({finished, dataOut} !== {2'b01, 32'h3F000000}) begin
      testsFailed++;
      $display("[TB] FAIL nonowner_finished: got fin=%b data=%h expected 01 3f000000", finished, dataOut);
    end
    applyStimulus(2'b10, '0, 2'b01, '0); tick;
    applyStimulus('0, '0, '0, '0);
    testsRun++;
    if ({reserved, finished} !== 4'b0000) begin
      testsFailed++;
      $display("[TB] FAIL nonowner_release: got res=%b fin=%b expected 00 00", reserved, finished);
    end
    tick;
  endtask

`ifdef FP_DIVSQRT_ARB_TIMEOUT_EN
  task automatic test_timeout;
    applyStimulus(2'b01, '0, '0, '0); tick;
    applyStimulus('0, '0, '0, '0);
    for (int c = 1; c <= TO + 1; c++) begin
      if (c > 1) tick;
      testsRun++;
      if ({reserved, timeoutPulse} !== ((c <= TO) ? {2'b01, (c == TO)} : 3'b000)) begin
        testsFailed++;
        $display("[TB] FAIL timeout_cycle%0d: got res=%b pulse=%b", c, reserved, timeoutPulse);
      end
    end
  endtask
`else
  task automatic test_timeout;
    applyStimulus(2'b01, '0, '0, '0); tick;
    applyStimulus('0, '0, '0, '0);
    for (int c = 0; c < 100; c++) begin
      tick;
      testsRun++;
      if ({reserved, timeoutPulse} !== 3'b010) begin
        testsFailed++;
        $display("[TB] FAIL hold_cycle%0d: got res=%b pulse=%b expected 01 0", c, reserved, timeoutPulse);
      end
    end
    applyStimulus('0, '0, '0, 2'b01); tick;
    applyStimulus('0, '0, '0, '0);
  endtask
`endif

  task automatic test_random;
    int holder = -1;
    int rrNext = 0;
    int waitCycles = 0;
    bit launched = 0, ready = 0, expStart, expAbort, expPulse;
    logic [31:0] mA = '0, mB = '0, mData = '0;
    logic [2:0]  mRm = '0;
    logic        mDiv = 1'b0;
    logic [4:0]  mFlags = '0;
    logic [N-1:0] expRes, expFin;
    doReset;
    for (int cyc = 0; cyc < 400; cyc++) begin
      reserveReq = N'($urandom);
      req        = N'($urandom);
      releaseReq = ($urandom_range(2) == 0) ? N'($urandom) : '0;
      flush      = ($urandom_range(11) == 0) ? N'($urandom) : '0;
      isDivide   = N'($urandom);
      dataInA    = {$urandom, $urandom};
      dataInB    = {$urandom, $urandom};
      rm         = 6'($urandom);
      coreDone   = ($urandom_range(4) == 0);
      coreResult = $urandom;
      coreFFlags = 5'($urandom);
      expStart = 0;
      expAbort = 0;
      if (holder < 0) begin
        for (int k = 0; k < N; k++) begin
          if (holder < 0 && reserveReq[(rrNext + k) % N]) begin
            holder     = (rrNext + k) % N;
            waitCycles = 1;
          end
        end
        if (holder >= 0) rrNext = (holder + 1) % N;
      end else if (!launched) begin
        if (flush[holder]) holder = -1;
`ifdef FP_DIVSQRT_ARB_TIMEOUT_EN
        else if (waitCycles == TO) holder = -1;
`endif
        else if (req[holder]) begin
          launched = 1;
          expStart = 1;
          mDiv = isDivide[holder];
          mA   = dataInA[holder*32 +: 32];
          mB   = dataInB[holder*32 +: 32];
          mRm  = rm[holder*3 +: 3];
        end else waitCycles++;
      end else if (!ready) begin
        if (flush[holder]) begin
          expAbort = !coreDone;
          holder   = -1;
          launched = 0;
        end else if (coreDone) begin
          ready  = 1;
          mData  = coreResult;
          mFlags = coreFFlags;
        end
      end else if (releaseReq[holder] || flush[holder]) begin
        holder   = -1;
        launched = 0;
        ready    = 0;
      end
      expRes = '0;
      expFin = '0;
      if (holder >= 0) expRes[holder] = 1'b1;
      if (ready) expFin[holder] = 1'b1;
      expPulse = 0;
`ifdef FP_DIVSQRT_ARB_TIMEOUT_EN
      expPulse = (holder >= 0) && !launched && (waitCycles == TO);
`endif
      tick;
      testsRun++;
      if ({reserved, finished, coreStart, coreAbort, timeoutPulse} !== {expRes, expFin, expStart, expAbort, expPulse}) begin
        testsFailed++;
        $display("[TB] FAIL rand_ctrl c%0d: got res=%b fin=%b st=%b ab=%b to=%b expected %b %b %b %b %b", cyc,
                 reserved, finished, coreStart, coreAbort, timeoutPulse, expRes, expFin, expStart, expAbort, expPulse);
      end
      testsRun++;
      if ({dataOut, fflagsOut} !== {mData, mFlags}) begin
        testsFailed++;
        $display("[TB] FAIL rand_result c%0d: got %h/%h expected %h/%h", cyc, dataOut, fflagsOut, mData, mFlags);
      end
      testsRun++;
      if ({coreIsDivide, coreA, coreB, coreRm} !== {mDiv, mA, mB, mRm}) begin
        testsFailed++;
        $display("[TB] FAIL rand_core c%0d: got %b %h %h %b expected %b %h %h %b", cyc,
                 coreIsDivide, coreA, coreB, coreRm, mDiv, mA, mB, mRm);
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    coreDone   = 1'b0;
    coreResult = '0;
    coreFFlags = '0;
    isDivide   = 2'b01;
    dataInA    = {32'h41200000, 32'h40400000};
    dataInB    = {32'h40000000, 32'h3F800000};
    rm         = {3'b110, 3'b001};
    applyStimulus('0, '0, '0, '0);
    test_reset;
    test_round_robin;
    test_divide;
    test_flush;
    test_non_owner;
    test_timeout;
    test_random;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
